// File: rtl/fft_out_pkg.sv
// Shared constants, sample types and FSM states for the FFT output serializer path.
package fft_out_pkg;

  localparam int unsigned DATA_WIDTH = 13;
  localparam int unsigned NFFT       = 512;
  localparam int unsigned LANES      = 32;
  localparam int unsigned BEATS      = NFFT / LANES;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned LANE_W     = $clog2(LANES);
  localparam int unsigned FCNT_W     = 8;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef sample_t [NFFT-1:0]           frame_t;
  typedef sample_t [LANES-1:0]          beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/fft_out_serializer_if.sv
// Beat stream from the serializer to a narrow consumer (valid/ready).
interface fft_out_serializer_if;
  import fft_out_pkg::*;

  logic              dout_valid;
  logic              dout_ready;
  beat_t             dout_R;
  beat_t             dout_Q;
  logic [BEAT_W-1:0] dout_beat;
  logic              dout_sof;
  logic              dout_eof;

  modport master (
    output dout_valid, dout_R, dout_Q, dout_beat, dout_sof, dout_eof,
    input  dout_ready
  );

  modport slave (
    input  dout_valid, dout_R, dout_Q, dout_beat, dout_sof, dout_eof,
    output dout_ready
  );

endinterface

// File: rtl/fft_out_beat_mux.sv
// Selects the 32-lane slice for one beat out of a 512-bin frame; zero when disabled.
module fft_out_beat_mux
  import fft_out_pkg::*;
(
  input  frame_t            buffer,
  input  logic [BEAT_W-1:0] beat,
  input  logic              en,
  output beat_t             lanes
);

  // Lane j of beat k is bin {k, j}
  always_comb begin
    lanes = '0;
    if (en) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        lanes[j] = buffer[{beat, LANE_W'(j)}];
      end
    end
  end

endmodule

// File: rtl/fft_out_serializer.sv
// Captures a reordered 512-bin I/Q frame and streams it as 16 beats of 32 bins.
module fft_out_serializer
  import fft_out_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  din_valid,
  input  frame_t                din_R,
  input  frame_t                din_Q,
  fft_out_serializer_if.master  dout,
  output logic                  busy,
  output logic                  overrun,
  output logic [FCNT_W-1:0]     frame_cnt
);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              ovr_q, ovr_d;
  logic              capture;
  logic              last_fire;
  logic              streaming;
  frame_t            buf_r, buf_q;

  // State, beat counter, frame counter and sticky overrun
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      fcnt_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      fcnt_q  <= fcnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame buffer holds its contents across reset; only the capture cycle writes it
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_r <= din_R;
      buf_q <= din_Q;
    end
  end

  // Next-state: capture from IDLE or on the last-beat fire, otherwise advance/drop
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    fcnt_d    = fcnt_q;
    ovr_d     = ovr_q;
    capture   = 1'b0;
    last_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          capture = 1'b1;
          beat_d  = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (dout.dout_ready) begin
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            last_fire = 1'b1;
            fcnt_d    = fcnt_q + FCNT_W'(1);
            beat_d    = '0;
            if (din_valid) begin
              capture = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        if (din_valid && !last_fire) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign streaming = (state_q == STREAM);

  // Output decode from registered state only; no path from dout_ready
  always_comb begin
    dout.dout_valid = streaming;
    dout.dout_beat  = streaming ? beat_q : '0;
    dout.dout_sof   = streaming && (beat_q == '0);
    dout.dout_eof   = streaming && (beat_q == BEAT_W'(BEATS - 1));
    busy            = streaming;
    overrun         = ovr_q;
    frame_cnt       = fcnt_q;
  end

  fft_out_beat_mux u_mux_r (
    .buffer (buf_r),
    .beat   (beat_q),
    .en     (streaming),
    .lanes  (dout.dout_R)
  );

  fft_out_beat_mux u_mux_q (
    .buffer (buf_q),
    .beat   (beat_q),
    .en     (streaming),
    .lanes  (dout.dout_Q)
  );

endmodule

// File: tb/tb_fft_out_serializer.sv
// Table-driven bench for fft_out_serializer plus a 256-frame chained wrap sequence.
module tb_fft_out_serializer;
  import fft_out_pkg::*;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              din_valid = 1'b0;
  frame_t            din_R = '0;
  frame_t            din_Q = '0;
  logic              busy;
  logic              overrun;
  logic [FCNT_W-1:0] frame_cnt;

  fft_out_serializer_if bus ();

  fft_out_serializer dut (
    .clk       (clk),
    .rstn      (rstn),
    .din_valid (din_valid),
    .din_R     (din_R),
    .din_Q     (din_Q),
    .dout      (bus),
    .busy      (busy),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rstn;
    logic dv;
    int   pat;
    logic rdy;
    logic ev;
    int   eb;
    logic ebusy;
    logic eovr;
    int   efc;
    int   epat;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Frame content patterns: bin n of pattern p
  function automatic int pat_i(int p, int n);
    case (p)
      0:       return n - 256;
      1:       return ((n * 37) % 8191) - 4096;
      2:       return (n % 2 == 1) ? 4095 : -4096;
      default: return 1000 - n;
    endcase
  endfunction

  function automatic int pat_q(int p, int n);
    case (p)
      0:       return 255 - n;
      1:       return 4095 - ((n * 11) % 8192);
      2:       return (n % 2 == 1) ? -4096 : 4095;
      default: return n - 1000;
    endcase
  endfunction

  task automatic add(input logic r, input logic dv, input int pat, input logic rdy,
                     input logic ev, input int eb, input logic ebusy, input logic eovr,
                     input int efc, input int epat);
    vec_t v;
    v.rstn = r; v.dv = dv; v.pat = pat; v.rdy = rdy;
    v.ev = ev; v.eb = eb; v.ebusy = ebusy; v.eovr = eovr; v.efc = efc; v.epat = epat;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then check all outputs just after the edge
  task automatic apply(input vec_t v, input int idx);
    logic       esof, eeof;
    int         gi, gq, ei, eq, bad_lane;
    @(negedge clk);
    rstn           = v.rstn;
    din_valid      = v.dv;
    bus.dout_ready = v.rdy;
    for (int n = 0; n < int'(NFFT); n++) begin
      din_R[n] = v.dv ? DATA_WIDTH'(pat_i(v.pat, n)) : '0;
      din_Q[n] = v.dv ? DATA_WIDTH'(pat_q(v.pat, n)) : '0;
    end
    @(posedge clk);
    #1;
    n_vec++;
    esof = v.ev && (v.eb == 0);
    eeof = v.ev && (v.eb == 15);
    if (bus.dout_valid !== v.ev || int'(bus.dout_beat) != v.eb || bus.dout_sof !== esof ||
        bus.dout_eof !== eeof || busy !== v.ebusy || overrun !== v.eovr ||
        int'(frame_cnt) != v.efc) begin
      n_err++;
      $display("FAIL ctrl vec %0d: got v=%b beat=%0d sof=%b eof=%b busy=%b ovr=%b fc=%0d, required v=%b beat=%0d sof=%b eof=%b busy=%b ovr=%b fc=%0d",
               idx, bus.dout_valid, bus.dout_beat, bus.dout_sof, bus.dout_eof, busy, overrun,
               frame_cnt, v.ev, v.eb, esof, eeof, v.ebusy, v.eovr, v.efc);
    end
    bad_lane = -1;
    gi = 0; gq = 0; ei = 0; eq = 0;
    for (int j = 0; j < int'(LANES); j++) begin
      int ti, tq, xi, xq;
      ti = int'($signed(bus.dout_R[j]));
      tq = int'($signed(bus.dout_Q[j]));
      xi = v.ev ? pat_i(v.epat, v.eb * 32 + j) : 0;
      xq = v.ev ? pat_q(v.epat, v.eb * 32 + j) : 0;
      if (bad_lane < 0 && (ti != xi || tq != xq)) begin
        bad_lane = j; gi = ti; gq = tq; ei = xi; eq = xq;
      end
    end
    if (bad_lane >= 0) begin
      n_err++;
      $display("FAIL data vec %0d lane %0d: got I=%0d Q=%0d, required I=%0d Q=%0d",
               idx, bad_lane, gi, gq, ei, eq);
    end
    // Bin 101 of the ramp frame: beat 3, lane 5
    if (v.ev && v.epat == 0 && v.eb == 3) begin
      if (int'($signed(bus.dout_R[5])) != -155 || int'($signed(bus.dout_Q[5])) != 154) begin
        n_err++;
        $display("FAIL bin101 vec %0d: got I=%0d Q=%0d, required I=-155 Q=154",
                 idx, $signed(bus.dout_R[5]), $signed(bus.dout_Q[5]));
      end
    end
  endtask

  initial begin
    int   b;
    logic r;
    vec_t w;
    bus.dout_ready = 1'b0;

    // Reset, then ready high while idle has no effect
    add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    // Single ramp frame, ready held high
    add(1, 1, 0, 1,  1, 0, 1, 0, 0, 0);
    for (int k = 1; k < 16; k++) add(1, 0, 0, 1,  1, k, 1, 0, 0, 0);
    add(1, 0, 0, 1,  0, 0, 0, 0, 1, 0);
    // Backpressure with an irregular ready pattern
    add(1, 1, 1, 0,  1, 0, 1, 0, 1, 1);
    b = 0;
    for (int c = 0; c < 200; c++) begin
      r = (c % 3 == 0) || (c % 5 == 2);
      if (r && b == 15) begin
        add(1, 0, 0, 1,  0, 0, 0, 0, 2, 0);
        break;
      end
      if (r) b++;
      add(1, 0, 0, r,  1, b, 1, 0, 1, 1);
    end
    // Seamless chaining: extremes frame, new frame captured on the beat-15 fire
    add(1, 1, 2, 1,  1, 0, 1, 0, 2, 2);
    for (int k = 1; k < 16; k++) add(1, 0, 0, 1,  1, k, 1, 0, 2, 2);
    add(1, 1, 3, 1,  1, 0, 1, 0, 3, 3);
    for (int k = 1; k < 16; k++) add(1, 0, 0, 1,  1, k, 1, 0, 3, 3);
    add(1, 0, 0, 1,  0, 0, 0, 0, 4, 0);
    // Overrun: new frames at beat 7 (stalled) and beat 8 (firing) are dropped
    add(1, 1, 0, 1,  1, 0, 1, 0, 4, 0);
    for (int k = 1; k < 8; k++) add(1, 0, 0, 1,  1, k, 1, 0, 4, 0);
    add(1, 1, 1, 0,  1, 7, 1, 1, 4, 0);
    add(1, 1, 1, 1,  1, 8, 1, 1, 4, 0);
    for (int k = 9; k < 16; k++) add(1, 0, 0, 1,  1, k, 1, 1, 4, 0);
    add(1, 0, 0, 1,  0, 0, 0, 1, 5, 0);
    // Later frame from idle keeps the sticky flag
    add(1, 1, 2, 1,  1, 0, 1, 1, 5, 2);
    for (int k = 1; k < 10; k++) add(1, 0, 0, 1,  1, k, 1, 1, 5, 2);
    // Reset at beat 9 dominates a simultaneous din_valid
    add(0, 1, 0, 1,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    add(1, 1, 3, 1,  1, 0, 1, 0, 0, 3);
    for (int k = 1; k < 16; k++) add(1, 0, 0, 1,  1, k, 1, 0, 0, 3);
    add(1, 0, 0, 1,  0, 0, 0, 0, 1, 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // 256 chained extremes frames: frame_cnt wraps back to 0
    w = '{rstn: 0, dv: 0, pat: 0, rdy: 0, ev: 0, eb: 0, ebusy: 0, eovr: 0, efc: 0, epat: 0};
    apply(w, 10000);
    w = '{rstn: 1, dv: 1, pat: 2, rdy: 1, ev: 1, eb: 0, ebusy: 1, eovr: 0, efc: 0, epat: 2};
    apply(w, 10001);
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 16; k++) begin
        w.rstn = 1; w.rdy = 1; w.pat = 2; w.epat = 2; w.eovr = 0;
        w.dv = (k == 15 && f < 255);
        if (k < 15) begin
          w.ev = 1; w.ebusy = 1; w.eb = k + 1; w.efc = f;
        end else if (f < 255) begin
          w.ev = 1; w.ebusy = 1; w.eb = 0; w.efc = f + 1;
        end else begin
          w.ev = 0; w.ebusy = 0; w.eb = 0; w.efc = 0;
        end
        apply(w, 20000 + f * 16 + k);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
